mc_ctrl_unit: RTL and testbench
===============================

# mc_ctrl_unit

Multi-cycle control unit for the single-issue MIPS core attached to each NoC tile. Owns the program counter and instruction register, fetches instruction words over a req/ack memory port, and feeds the IR to the field decoder. Sequences fetch/decode/execute/memory/writeback, and drives every datapath control strobe (ALU, register file, memory) from its state and the decoded opcode/funct.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_req  out  1  memory access request, held until acked
- mem_we  out  1  write qualifier for mem_req (sw only)
- mem_addr_sel  out  1  0 = address from pc, 1 = address from ALU result register
- mem_ack  in  1  access complete; rdata valid same cycle for reads
- mem_rdata  in  32  read data (instruction word during fetch)
- instr  out  32  IR contents, to field decoder
- pc  out  32  current PC
- alu_zero  in  1  ALU zero flag (used in BRANCH)
- alu_src_a  out  1  0 = pc, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file write enable, dest select (0 rt / 1 rd), writeback source (0 ALU / 1 memory)
- trap  out  1  sticky illegal-instruction flag (see Configuration)

## Operation
- States: FETCH, DECODE, EX_R, EX_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On mem_ack: IR <= mem_rdata, pc <= pc+4, -> DECODE. Without ack: stay, outputs held.
- DECODE: one cycle; dispatch on IR[31:26]: 0x00 -> EX_R if funct in {0x20,0x22,0x24,0x25,0x2A}; 0x08 -> EX_I; 0x23/0x2B -> MEM_ADDR; 0x04 -> BRANCH; 0x02 -> JUMP; anything else illegal.
- EX_R: alu_src_a=1, alu_src_b=0, alu_ctrl from funct (add/sub/and/or/slt) -> WB_R (reg_write=1, reg_dst=1, mem_to_reg=0) -> FETCH.
- EX_I (addi): src_a=1, src_b=2, add -> WB_I (reg_write=1, reg_dst=0) -> FETCH.
- MEM_ADDR: src_a=1, src_b=2, add -> MEM_RD (lw) or MEM_WR (sw). Both hold mem_req=1, mem_addr_sel=1 until mem_ack; MEM_WR asserts mem_we. MEM_RD -> WB_MEM (reg_write=1, reg_dst=0, mem_to_reg=1); MEM_WR -> FETCH.
- BRANCH (beq): src_a=1, src_b=0, sub. If alu_zero: pc <= pc + (sext(imm)<<2), with pc already PC+4. -> FETCH.
- JUMP: pc <= {pc[31:28], IR[25:0], 2'b00} -> FETCH.
- Illegal: -> FETCH, instruction treated as NOP.
- All outputs not listed for a state are 0. Outputs are a Moore decode of state plus IR; no glitch constraint.
- PC arithmetic is 32-bit modulo; wrap 0xFFFF_FFFC + 4 -> 0x0000_0000, no flag.

## Timing
- Reset (async assert, sync-safe deassert): state=FETCH, pc=RESET_PC, IR=0, trap=0. mem_req=1 from the first cycle after deassert.
- mem_ack may arrive in the same cycle as mem_req (zero wait). N wait cycles add N cycles.
- Zero-wait cycle counts: R-type/addi 4, lw 5, sw 4, beq/j 3.
- Reset mid-access abandons the request. Memory must drop it on rst_n low.
- mem_ack outside FETCH/MEM_RD/MEM_WR is ignored.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined: an illegal instruction in DECODE -> TRAP. TRAP is terminal until reset: trap=1, all strobes 0, pc frozen at the illegal instruction address + 4.
- Undefined: illegal instructions are NOPs, trap tied to 0, and the TRAP state is not present.

## Structure
- Package mc_ctrl_pkg: state enum, opcode and funct constants, alu_ctrl encodings, alu_src_b encodings.
- Sub-module mc_alu_ctrl_dec: combinational funct -> alu_ctrl plus legal flag. Used by DECODE legality and EX_R.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory: first mem_req with pc=0x100; pc=0x104 after ack; state DECODE the next cycle.
- Fetch 0x012A4020 (add $8,$9,$10): EX_R has alu_ctrl=010, src_a=1, src_b=0; WB_R has reg_write=1, reg_dst=1; 4 cycles total.
- lw 0x8D090004 with mem_ack delayed 3 cycles in MEM_RD: mem_req and mem_addr_sel held; WB_MEM has mem_to_reg=1; 8 cycles total.
- beq at 0x200 with imm=0xFFFF, alu_zero=1: pc becomes 0x200. With alu_zero=0: pc becomes 0x204.
- j at 0x4000_0010 with target 0x000_0040: pc becomes 0x4000_0100.
- Opcode 0x3F. Macro defined: trap=1, mem_req stays 0 indefinitely, rst_n low clears trap. Macro undefined: next fetch at pc+4.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN adds the terminal TRAP state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EX_R,
        ST_EX_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_R,
        ST_WB_I,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

    // Where DECODE sends an instruction it does not recognise
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_t ST_ILLEGAL = ST_TRAP;
`else
    localparam state_t ST_ILLEGAL = ST_FETCH;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SB_RT     = 2'd0;
    localparam logic [1:0] SB_FOUR   = 2'd1;
    localparam logic [1:0] SB_IMM    = 2'd2;
    localparam logic [1:0] SB_IMM_X4 = 2'd3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    // Word-aligned, sign-extended branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Strobe set for a state; r_alu is the funct-derived ALU op for R-type
    function automatic ctrl_t state_ctrl(input state_t st, input logic [2:0] r_alu);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:    c.mem_req = 1'b1;
            ST_EX_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SB_RT;
                c.alu_ctrl  = r_alu;
            end
            ST_EX_I, ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SB_IMM;
                c.alu_ctrl  = ALU_ADD;
            end
            ST_MEM_RD: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.mem_we       = 1'b1;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_WB_I:     c.reg_write = 1'b1;
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SB_RT;
                c.alu_ctrl  = ALU_SUB;
            end
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_ctrl_dec.sv
// R-type funct decoder: ALU operation plus a legality flag.
// Unaffected by MC_CTRL_ILLEGAL_TRAP_EN.
module mc_alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    // Map the supported functs; anything else is flagged illegal
    always_comb begin
        alu_ctrl = ALU_AND;
        legal    = 1'b0;
        case (funct)
            FN_ADD: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
            FN_SUB: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
            FN_AND: begin alu_ctrl = ALU_AND; legal = 1'b1; end
            FN_OR:  begin alu_ctrl = ALU_OR;  legal = 1'b1; end
            FN_SLT: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
            default: begin alu_ctrl = ALU_AND; legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control unit: owns PC and IR, sequences fetch through
// writeback and drives all datapath strobes as registered outputs.
// Define MC_CTRL_ILLEGAL_TRAP_EN to make illegal instructions trap.
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        alu_zero,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        trap
);

    state_t      state;
    state_t      nxt_state;
    logic [31:0] nxt_pc;
    logic [31:0] nxt_ir;
    logic [2:0]  r_alu;
    logic        r_legal;
    logic [5:0]  opcode;
    ctrl_t       ctrl;

    assign opcode = instr[31:26];

    mc_alu_ctrl_dec u_alu_dec (
        .funct    (instr[5:0]),
        .alu_ctrl (r_alu),
        .legal    (r_legal)
    );

    // Next state, PC and IR from the current state, IR and memory handshake
    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        nxt_ir    = instr;
        case (state)
            ST_FETCH: begin
                if (mem_ack) begin
                    nxt_ir    = mem_rdata;
                    nxt_pc    = pc + 32'd4;
                    nxt_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt_state = r_legal ? ST_EX_R : ST_ILLEGAL;
                    OP_ADDI:      nxt_state = ST_EX_I;
                    OP_LW, OP_SW: nxt_state = ST_MEM_ADDR;
                    OP_BEQ:       nxt_state = ST_BRANCH;
                    OP_J:         nxt_state = ST_JUMP;
                    default:      nxt_state = ST_ILLEGAL;
                endcase
            end
            ST_EX_R:     nxt_state = ST_WB_R;
            ST_EX_I:     nxt_state = ST_WB_I;
            ST_MEM_ADDR: nxt_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ack) nxt_state = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ack) nxt_state = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM: nxt_state = ST_FETCH;
            ST_BRANCH: begin
                if (alu_zero) nxt_pc = pc + branch_offset(instr[15:0]);
                nxt_state = ST_FETCH;
            end
            ST_JUMP: begin
                nxt_pc    = {pc[31:28], instr[25:0], 2'b00};
                nxt_state = ST_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:     nxt_state = ST_TRAP;
`endif
            default:     nxt_state = ST_FETCH;
        endcase
    end

    // State, PC, IR and the strobes for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            instr <= '0;
            ctrl  <= state_ctrl(ST_FETCH, ALU_ADD);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            trap  <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            pc    <= nxt_pc;
            instr <= nxt_ir;
            ctrl  <= state_ctrl(nxt_state, r_alu);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            trap  <= (nxt_state == ST_TRAP);
`endif
        end
    end

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    assign trap = 1'b0;
`endif

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign mem_addr_sel = ctrl.mem_addr_sel;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_ctrl     = ctrl.alu_ctrl;
    assign reg_write    = ctrl.reg_write;
    assign reg_dst      = ctrl.reg_dst;
    assign mem_to_reg   = ctrl.mem_to_reg;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit. Each instruction is expanded into
// a per-cycle list of expected strobes, PC and IR from the instruction's
// class, then replayed against the DUT. Follows MC_CTRL_ILLEGAL_TRAP_EN.
module tb_mc_ctrl_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] CLIMB_TARGET = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel;
    logic [31:0] instr, pc;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        reg_write, reg_dst, mem_to_reg, trap;

    mc_ctrl_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .pc           (pc),
        .alu_zero     (alu_zero),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ctrl     (alu_ctrl),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] ctl;
        logic        ack;
        logic        zero;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] ir;
    } step_t;

    step_t       plan[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_ir = '0;

    // Expected strobe vector: req, we, addr_sel, src_a, src_b, alu, rw, rdst, m2r, trap
    function automatic logic [13:0] mk(input bit req, input bit we, input bit asel,
                                       input bit sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input bit rw,
                                       input bit rd, input bit m2r, input bit tr);
        return {req, we, asel, sa, sb, alu, rw, rd, m2r, tr};
    endfunction

    // {legal, alu op} for an R-type funct, straight from the instruction table
    function automatic logic [3:0] r_info(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b1_010;
            6'h22:   return 4'b1_110;
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h2A:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    task automatic add_step(input logic [13:0] ctl, input logic ack, input logic [31:0] rdata);
        step_t s;
        s.ctl   = ctl;
        s.ack   = ack;
        s.zero  = 1'($urandom_range(0, 1));
        s.rdata = rdata;
        s.pc    = m_pc;
        s.ir    = m_ir;
        plan.push_back(s);
    endtask

    // Expand one instruction into its expected cycles and update the PC model
    task automatic plan_instr(input logic [31:0] word, input int fetch_wait,
                              input int mem_wait, input bit zero);
        logic [5:0]  op;
        logic [3:0]  ri;
        step_t       s;
        op = word[31:26];
        ri = r_info(word[5:0]);
        for (int i = 0; i <= fetch_wait; i++)
            add_step(mk(1,0,0,0,2'd0,3'b000,0,0,0,0), 1'(i == fetch_wait),
                     (i == fetch_wait) ? word : $urandom());
        m_pc = m_pc + 32'd4;
        m_ir = word;
        add_step('0, 1'($urandom_range(0, 1)), $urandom());
        case (op)
            6'h00: begin
                if (ri[3]) begin
                    add_step(mk(0,0,0,1,2'd0,ri[2:0],0,0,0,0), 1'($urandom_range(0, 1)), $urandom());
                    add_step(mk(0,0,0,0,2'd0,3'b000,1,1,0,0), 1'($urandom_range(0, 1)), $urandom());
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                else repeat (6) add_step(mk(0,0,0,0,2'd0,3'b000,0,0,0,1), 1'($urandom_range(0, 1)), $urandom());
`endif
            end
            6'h08: begin
                add_step(mk(0,0,0,1,2'd2,3'b010,0,0,0,0), 1'($urandom_range(0, 1)), $urandom());
                add_step(mk(0,0,0,0,2'd0,3'b000,1,0,0,0), 1'($urandom_range(0, 1)), $urandom());
            end
            6'h23: begin
                add_step(mk(0,0,0,1,2'd2,3'b010,0,0,0,0), 1'($urandom_range(0, 1)), $urandom());
                for (int i = 0; i <= mem_wait; i++)
                    add_step(mk(1,0,1,0,2'd0,3'b000,0,0,0,0), 1'(i == mem_wait), $urandom());
                add_step(mk(0,0,0,0,2'd0,3'b000,1,0,1,0), 1'($urandom_range(0, 1)), $urandom());
            end
            6'h2B: begin
                add_step(mk(0,0,0,1,2'd2,3'b010,0,0,0,0), 1'($urandom_range(0, 1)), $urandom());
                for (int i = 0; i <= mem_wait; i++)
                    add_step(mk(1,1,1,0,2'd0,3'b000,0,0,0,0), 1'(i == mem_wait), $urandom());
            end
            6'h04: begin
                s.ctl   = mk(0,0,0,1,2'd0,3'b110,0,0,0,0);
                s.ack   = 1'($urandom_range(0, 1));
                s.zero  = zero;
                s.rdata = $urandom();
                s.pc    = m_pc;
                s.ir    = m_ir;
                plan.push_back(s);
                if (zero) m_pc = m_pc + {{14{word[15]}}, word[15:0], 2'b00};
            end
            6'h02: begin
                add_step('0, 1'($urandom_range(0, 1)), $urandom());
                m_pc = {m_pc[31:28], word[25:0], 2'b00};
            end
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                repeat (6) add_step(mk(0,0,0,0,2'd0,3'b000,0,0,0,1), 1'($urandom_range(0, 1)), $urandom());
`endif
            end
        endcase
    endtask

    task automatic checkOutput(input step_t s);
        logic [13:0] obs;
        obs = {mem_req, mem_we, mem_addr_sel, alu_src_a, alu_src_b, alu_ctrl,
               reg_write, reg_dst, mem_to_reg, trap};
        total++;
        assert (obs === s.ctl) else begin
            bad++;
            $error("[TB] FAIL strobes pc=%h observed=%b expected=%b", s.pc, obs, s.ctl);
        end
        total++;
        assert (pc === s.pc) else begin
            bad++;
            $error("[TB] FAIL pc observed=%h expected=%h", pc, s.pc);
        end
        total++;
        assert (instr === s.ir) else begin
            bad++;
            $error("[TB] FAIL instr observed=%h expected=%h", instr, s.ir);
        end
    endtask

    // Replay the planned cycles: check at the falling edge, then drive inputs
    task automatic applyStimulus();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            checkOutput(s);
            mem_ack   = s.ack;
            alu_zero  = s.zero;
            mem_rdata = s.rdata;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        total++;
        assert (pc === RST_PC) else begin
            bad++;
            $error("[TB] FAIL reset_pc observed=%h expected=%h", pc, RST_PC);
        end
        total++;
        assert (instr === 32'h0) else begin
            bad++;
            $error("[TB] FAIL reset_ir observed=%h expected=%h", instr, 32'h0);
        end
        total++;
        assert (trap === 1'b0) else begin
            bad++;
            $error("[TB] FAIL reset_trap observed=%b expected=%b", trap, 1'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc  = RST_PC;
        m_ir  = '0;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] diff;
        logic [31:0] off;
        logic [5:0]  legal_fn [5];
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        $display("[TB] reset and directed instructions");
        doReset();
        plan_instr(32'h012A_4020, 0, 0, 0); applyStimulus();
        plan_instr(32'h8D09_0004, 0, 3, 0); applyStimulus();
        plan_instr(32'hAD09_0008, 2, 1, 0); applyStimulus();
        plan_instr(32'h2128_0005, 1, 0, 0); applyStimulus();
        plan_instr(32'h012A_4022, 0, 0, 0); applyStimulus();
        plan_instr(32'h012A_4024, 0, 0, 0); applyStimulus();
        plan_instr(32'h012A_4025, 0, 0, 0); applyStimulus();
        plan_instr(32'h012A_402A, 0, 0, 0); applyStimulus();
        plan_instr(32'h0800_0080, 0, 0, 0); applyStimulus();
        plan_instr(32'h1000_FFFF, 0, 0, 1); applyStimulus();
        plan_instr(32'h1000_FFFF, 0, 0, 0); applyStimulus();

        $display("[TB] wrap at top of address space");
        off = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
        plan_instr({16'h1000, off[15:0]}, 0, 0, 1); applyStimulus();
        plan_instr(32'h2108_0001, 0, 0, 0); applyStimulus();

        $display("[TB] randomized instruction mix");
        for (int n = 0; n < 40; n++) begin
            w = $urandom();
            case ($urandom_range(0, 5))
                0: begin w[31:26] = 6'h00; w[10:6] = 5'h0; w[5:0] = legal_fn[$urandom_range(0, 4)]; end
                1: w[31:26] = 6'h08;
                2: w[31:26] = 6'h23;
                3: w[31:26] = 6'h2B;
                4: begin w[31:26] = 6'h04; w[15:0] = 16'($urandom_range(0, 64)) - 16'd32; end
                default: w[31:26] = 6'h02;
            endcase
            plan_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            applyStimulus();
        end

        $display("[TB] branch up to 0x40000010 then jump");
        diff = CLIMB_TARGET - m_pc;
        while (diff > 32'h0002_0000) begin
            plan_instr(32'h1000_7FFF, 0, 0, 1);
            applyStimulus();
            diff = CLIMB_TARGET - m_pc;
        end
        off = (diff - 32'd4) >> 2;
        plan_instr({16'h1000, off[15:0]}, 0, 0, 1); applyStimulus();
        plan_instr(32'h0800_0040, 0, 0, 0); applyStimulus();
        plan_instr(32'h012A_4020, 0, 0, 0); applyStimulus();

        $display("[TB] illegal instruction handling");
        plan_instr(32'hFC00_0000, 1, 0, 0); applyStimulus();
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        plan_instr(32'h012A_4021, 0, 0, 0); applyStimulus();
        plan_instr(32'h012A_4020, 0, 0, 0); applyStimulus();
        add_step(mk(1,0,0,0,2'd0,3'b000,0,0,0,0), 1'b0, $urandom());
        add_step(mk(1,0,0,0,2'd0,3'b000,0,0,0,0), 1'b0, $urandom());
        applyStimulus();
`endif
        doReset();
        plan_instr(32'h012A_4020, 0, 0, 0); applyStimulus();
        plan_instr(32'h2128_0005, 0, 0, 0); applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
